programmable_counter: RTL and testbench
=======================================

PROGRAMMABLE_COUNTER -- requirements
Module: programmable_counter

Interface
REQ-001 Parameter S, default 8, meaning counter width in bits; SHALL be even and >= 2.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to load load_val and begin counting; sampled only in IDLE.
REQ-005 load_val  input  S  start value captured on an accepted start.
REQ-006 en  input  1  count enable; increments only in COUNT when high.
REQ-007 abort  input  1  synchronous cancel of an active run.
REQ-008 count  output  S  current counter value, registered.
REQ-009 busy  output  1  high while in COUNT.
REQ-010 done  output  1  one-cycle pulse when a run wraps to zero.

Function
REQ-011 FSM states SHALL be IDLE, COUNT and DONE.
REQ-012 IDLE with start=1: next cycle count=load_val, state=COUNT, busy=1.
REQ-013 IDLE with start=0: count holds, state stays IDLE.
REQ-014 COUNT, en=1, abort=0: count <= incrementer sum, i.e. count+1 mod 2^S.
REQ-015 COUNT, en=0, abort=0: count and state hold; no done.
REQ-016 COUNT, en=1, incrementer carry-out=1 (count all-ones): count <= 0, state <= DONE.
REQ-017 DONE: done=1 for exactly that cycle, busy=0, count=0; next state IDLE unconditionally.
REQ-018 start in COUNT or DONE SHALL be ignored, not queued.
REQ-019 abort in COUNT: next cycle state=IDLE, count holds its current value, no done pulse; abort has priority over en.
REQ-020 abort in IDLE or DONE SHALL have no effect.
REQ-021 Run length: an accepted start with load_val=V SHALL produce done after exactly 2^S - V enabled COUNT cycles; V=0 runs a full 2^S cycles.
REQ-022 load_val all-ones SHALL finish on the first enabled COUNT cycle.
REQ-023 busy SHALL be a registered decode of state; done SHALL be asserted only in DONE.
REQ-024 Outputs SHALL be glitch-free registered or state-decoded; no combinational path from inputs to outputs.

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE, count=0, busy=0, done=0, independent of clk.
REQ-026 rst asserted mid-run SHALL discard the run; after release the block waits in IDLE for a new start.
REQ-027 First accepted start SHALL be the first rising edge with rst=0 and start=1.

Structure
REQ-028 Shared package SHALL hold the state typedef (IDLE, COUNT, DONE) and the default width constant.
REQ-029 Next-value logic SHALL be a single instance of NMI_using_TMI #(.S(S)) with input count, sum as next value, carry-out as wrap detect; no '+' operator in this block.
REQ-030 One always_ff for state and count, one always_comb for next-state; no other sub-modules.

Verification (S=8)
REQ-031 rst pulse mid-COUNT at count=8'h37 -> count=0, busy=0 immediately; no done after release.
REQ-032 start, load_val=8'hFC, en=1 constant -> count FD, FE, FF, 00; done high one cycle on the 4th enabled cycle; busy low next.
REQ-033 start, load_val=8'hF0, en toggling 1/0 -> done after exactly 16 en-high cycles; count holds on en-low cycles.
REQ-034 start, load_val=8'h10, abort at count=8'h20 with en=1 -> IDLE, count stays 8'h20, done never asserts.
REQ-035 start held high through a full run with load_val=8'hFF -> done after 1 cycle; second start accepted only after return to IDLE, re-loading 8'hFF.
REQ-036 start, load_val=8'h00, en=1 -> done after exactly 256 cycles, count wraps FF->00.

Source files
------------

// File: rtl/programmable_counter_pkg.sv
// Shared definitions for the programmable counter.
//   state_t      : FSM state type (IDLE, COUNT, DONE)
//   DefaultWidth : default counter width in bits
package programmable_counter_pkg;

    localparam int unsigned DefaultWidth = 8;

    // Encoding keeps busy and done as single register bits: bit 0 = COUNT, bit 1 = DONE.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/NMI_using_TMI.sv
// N-bit modular incrementer built from a chain of 2-bit incrementer slices.
// Computes sum = a + 1 mod 2^S without an adder; carry_out is high when a is all-ones.
//   a         : S-bit operand (S even, >= 2)
//   sum       : S-bit incremented value
//   carry_out : wrap indication
module NMI_using_TMI
    import programmable_counter_pkg::*;
#(
    parameter int unsigned S = DefaultWidth
) (
    input  logic [S-1:0] a,
    output logic [S-1:0] sum,
    output logic         carry_out
);

    localparam int unsigned Pairs = S / 2;

    logic [Pairs:0] carry;

    // Increment is a carry-in of one into the lowest slice.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < Pairs; i++) begin : g_tmi
        assign sum[2*i]     = a[2*i] ^ carry[i];
        assign sum[2*i+1]   = a[2*i+1] ^ (a[2*i] & carry[i]);
        assign carry[i+1]   = carry[i] & a[2*i] & a[2*i+1];
    end

    assign carry_out = carry[Pairs];

endmodule

// File: rtl/programmable_counter.sv
// Programmable up-counter: loads load_val on start, counts on en, pulses done on wrap to zero.
//   clk      : clock (rising edge)
//   rst      : asynchronous active-high reset
//   start    : load load_val and begin a run (honoured only in IDLE)
//   load_val : start value
//   en       : count enable while running
//   abort    : cancel a run, count holds
//   count    : registered counter value
//   busy     : high while counting
//   done     : one-cycle pulse after the run wraps
module programmable_counter
    import programmable_counter_pkg::*;
#(
    parameter int unsigned S = DefaultWidth
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [S-1:0] load_val,
    input  logic         en,
    input  logic         abort,
    output logic [S-1:0] count,
    output logic         busy,
    output logic         done
);

    state_t       state_q, state_d;
    logic [S-1:0] count_q, count_d;
    logic [S-1:0] inc_sum;
    logic         inc_carry;

    NMI_using_TMI #(.S(S)) u_inc (
        .a         (count_q),
        .sum       (inc_sum),
        .carry_out (inc_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = load_val;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                // abort wins over en and leaves count where it is
                if (abort) begin
                    state_d = IDLE;
                end else if (en) begin
                    count_d = inc_sum;
                    if (inc_carry) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                count_d = '0;
                state_d = IDLE;
            end
            default: begin
                count_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Outputs come straight from register bits thanks to the state encoding.
    assign count = count_q;
    assign busy  = state_q[0];
    assign done  = state_q[1];

endmodule

// File: tb/tb_programmable_counter.sv
module tb_programmable_counter;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] load_val;
    logic       en;
    logic       abort;
    logic [7:0] count;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    programmable_counter #(.S(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .load_val (load_val),
        .en       (en),
        .abort    (abort),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_cnt;
        logic [7:0] prev;
        int         n;
        bit         got;

        rst      = 1'b1;
        start    = 1'b0;
        load_val = 8'h00;
        en       = 1'b0;
        abort    = 1'b0;

        // Reset state, before any clock edge
        #2;
        check("rst_count", 32'(count), 32'h00);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        tick();
        rst = 1'b0;

        // Idle without start holds
        tick();
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_count", 32'(count), 32'h00);

        // load FC, en high: FD FE FF 00 + done
        start = 1'b1; load_val = 8'hFC; en = 1'b1;
        tick();
        start = 1'b0;
        check("fc_load", 32'(count), 32'hFC);
        check("fc_busy", 32'(busy), 32'h1);
        tick(); check("fc_1", 32'(count), 32'hFD); check("fc_1_done", 32'(done), 32'h0);
        tick(); check("fc_2", 32'(count), 32'hFE);
        tick(); check("fc_3", 32'(count), 32'hFF); check("fc_3_done", 32'(done), 32'h0);
        tick();
        check("fc_4", 32'(count), 32'h00);
        check("fc_4_done", 32'(done), 32'h1);
        check("fc_4_busy", 32'(busy), 32'h0);
        tick();
        check("fc_after_done", 32'(done), 32'h0);
        check("fc_after_busy", 32'(busy), 32'h0);

        // Asynchronous reset mid-run at 37
        start = 1'b1; load_val = 8'h30; en = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("pre_rst_count", 32'(count), 32'h37);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_count", 32'(count), 32'h00);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_done", 32'(done), 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_done", 32'(done), 32'h0);
            check("post_rst_busy", 32'(busy), 32'h0);
            check("post_rst_count", 32'(count), 32'h00);
        end

        // load F0, en toggling: done after 16 enabled cycles
        start = 1'b1; load_val = 8'hF0; en = 1'b0;
        tick();
        start = 1'b0;
        check("f0_load", 32'(count), 32'hF0);
        exp_cnt = 8'hF0;
        for (int k = 0; k < 15; k++) begin
            en = 1'b1;
            tick();
            exp_cnt = exp_cnt + 8'd1;
            check("f0_en_count", 32'(count), 32'(exp_cnt));
            check("f0_en_done", 32'(done), 32'h0);
            en = 1'b0;
            tick();
            check("f0_hold_count", 32'(count), 32'(exp_cnt));
            check("f0_hold_busy", 32'(busy), 32'h1);
        end
        en = 1'b1;
        tick();
        check("f0_done", 32'(done), 32'h1);
        check("f0_done_count", 32'(count), 32'h00);
        tick();

        // load 10, abort at 20 with en high
        start = 1'b1; load_val = 8'h10; en = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        check("pre_abort_count", 32'(count), 32'h20);
        abort = 1'b1;
        tick();
        check("abort_count", 32'(count), 32'h20);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        tick();
        // abort in IDLE has no effect
        check("abort_idle_count", 32'(count), 32'h20);
        check("abort_idle_busy", 32'(busy), 32'h0);
        check("abort_idle_done", 32'(done), 32'h0);
        abort = 1'b0;
        tick();
        check("abort_idle2_done", 32'(done), 32'h0);

        // start held through a run, load FF
        start = 1'b1; load_val = 8'hFF; en = 1'b1;
        tick();
        check("ff_load", 32'(count), 32'hFF);
        check("ff_busy", 32'(busy), 32'h1);
        tick();
        check("ff_done", 32'(done), 32'h1);
        check("ff_done_count", 32'(count), 32'h00);
        tick();
        check("ff_idle_busy", 32'(busy), 32'h0);
        check("ff_idle_count", 32'(count), 32'h00);
        tick();
        start = 1'b0;
        check("ff_reload", 32'(count), 32'hFF);
        check("ff_reload_busy", 32'(busy), 32'h1);
        tick();
        check("ff_done2", 32'(done), 32'h1);
        tick();

        // load 00, full 256-cycle run
        start = 1'b1; load_val = 8'h00; en = 1'b1;
        tick();
        start = 1'b0;
        check("full_load_busy", 32'(busy), 32'h1);
        n    = 0;
        prev = 8'h00;
        got  = 1'b0;
        while (n < 300 && !got) begin
            prev = count;
            tick();
            n++;
            if (done) got = 1'b1;
        end
        check("full_run_len", 32'(n), 32'd256);
        check("full_run_prev", 32'(prev), 32'hFF);
        check("full_run_count", 32'(count), 32'h00);
        tick();
        check("full_run_idle", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
